// File: rtl/xpmwrap_stream_reader_pkg.sv
// Shared types and sizing helpers for the SDP RAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xpmwrap_stream_reader_pkg;

    localparam int RD_DATA_W = 32;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
`ifdef SDPRAM_STREAM_READER_ECC_EN
        logic                 sbiterr;
        logic                 dbiterr;
`endif
        logic [RD_DATA_W-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/xpmwrap_fwft_buf.sv
// Circular first-word-fall-through buffer of rd_entry_t words with occupancy count.
// Latency: a pushed word is presented on pop_dat the cycle after the push.
// Backpressure: pop only on pop_vld & pop_rdy; push has no ready, the caller guarantees space.
module xpmwrap_fwft_buf
    import xpmwrap_stream_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  rd_entry_t        push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output rd_entry_t        pop_dat,
    output logic [CNT_W-1:0] cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    rd_entry_t        mem_q [DEPTH];
    rd_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;

    assign pop_vld = (cnt_q != '0);
    assign cnt     = cnt_q;
    // Output is zeroed while empty so stale entries never leak onto the bus.
    assign pop_dat = pop_vld ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        pop      = pop_vld & pop_rdy;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push_vld) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/xpmwrap_sdpram_stream_reader.sv
// Read-side stream controller for the SDP RAM wrapper; ECC flags via SDPRAM_STREAM_READER_ECC_EN.
// Latency: request accepted at cycle N is presented at N+READ_LATENCY+1 when the buffer is empty.
// Backpressure: issue is credit-limited by buffer space, so returning RAM data is never stalled.
module xpmwrap_sdpram_stream_reader
    import xpmwrap_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH_A       = 6,
    parameter int WRITE_DATA_WIDTH_A = RD_DATA_W,
    parameter int READ_LATENCY       = 2,
    parameter int BUF_DEPTH          = 4
) (
    input  logic                              clkb,
    input  logic                              rstb,
    input  logic                              s_raddr_valid,
    output logic                              s_raddr_ready,
    input  logic [ADDR_WIDTH_A-1:0]           s_raddr,
    output logic                              m_rdata_valid,
    input  logic                              m_rdata_ready,
    output logic [WRITE_DATA_WIDTH_A-1:0]     m_rdata,
    output logic [ADDR_WIDTH_A-1:0]           mem_addrb,
    output logic                              mem_enb,
    output logic                              mem_regceb,
    input  logic [WRITE_DATA_WIDTH_A-1:0]     mem_doutb,
`ifdef SDPRAM_STREAM_READER_ECC_EN
    input  logic                              mem_sbiterrb,
    input  logic                              mem_dbiterrb,
    output logic                              m_sbiterr,
    output logic                              m_dbiterr,
    output logic [15:0]                       err_cnt,
`endif
    output logic [cnt_width(BUF_DEPTH)-1:0]   inflight
);
    localparam int CNT_W = cnt_width(BUF_DEPTH);

    logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [CNT_W-1:0]        pipe_cnt;
    logic [CNT_W-1:0]        buf_cnt;
    logic                    issue;
    rd_entry_t               ret_dat;
    rd_entry_t               out_dat;

    // Every read in the pipe already owns a buffer slot, so the sum is the credit in use.
    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_cnt = pipe_cnt + CNT_W'(vld_sr_q[i]);
        end
        inflight      = pipe_cnt + buf_cnt;
        s_raddr_ready = ~rstb & (inflight < CNT_W'(BUF_DEPTH));
        issue         = s_raddr_valid & s_raddr_ready;
        vld_sr_d      = (vld_sr_q << 1) | READ_LATENCY'(issue);
    end

    assign mem_enb    = issue;
    assign mem_addrb  = s_raddr;
    assign mem_regceb = 1'b1;

    always_comb begin
        ret_dat      = '0;
        ret_dat.data = mem_doutb;
`ifdef SDPRAM_STREAM_READER_ECC_EN
        ret_dat.sbiterr = mem_sbiterrb;
        ret_dat.dbiterr = mem_dbiterrb;
`endif
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
        end
    end

    xpmwrap_fwft_buf #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk      (clkb),
        .rst      (rstb),
        .push_vld (vld_sr_q[READ_LATENCY-1]),
        .push_dat (ret_dat),
        .pop_vld  (m_rdata_valid),
        .pop_rdy  (m_rdata_ready),
        .pop_dat  (out_dat),
        .cnt      (buf_cnt)
    );

    assign m_rdata = out_dat.data;

`ifdef SDPRAM_STREAM_READER_ECC_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    assign m_sbiterr = out_dat.sbiterr;
    assign m_dbiterr = out_dat.dbiterr;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (m_rdata_valid && m_rdata_ready && (out_dat.sbiterr || out_dat.dbiterr)
            && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_xpmwrap_sdpram_stream_reader.sv
// Bench for xpmwrap_sdpram_stream_reader: behavioural 2-cycle RAM, queue-based reference model,
// per-cycle compare process, and directed scenarios pinned with literal expectations.
module tb_xpmwrap_sdpram_stream_reader;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int BD = 4;
    localparam int CW = $clog2(BD + 1);

    logic          clkb = 1'b0;
    logic          rstb = 1'b1;
    logic          s_raddr_valid = 1'b0;
    logic          s_raddr_ready;
    logic [AW-1:0] s_raddr = '0;
    logic          m_rdata_valid;
    logic          m_rdata_ready = 1'b0;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] mem_addrb;
    logic          mem_enb;
    logic          mem_regceb;
    logic [DW-1:0] mem_doutb;
    logic [CW-1:0] inflight;
`ifdef SDPRAM_STREAM_READER_ECC_EN
    logic          mem_sbiterrb;
    logic          mem_dbiterrb;
    logic          m_sbiterr;
    logic          m_dbiterr;
    logic [15:0]   err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    xpmwrap_sdpram_stream_reader dut (
        .clkb          (clkb),
        .rstb          (rstb),
        .s_raddr_valid (s_raddr_valid),
        .s_raddr_ready (s_raddr_ready),
        .s_raddr       (s_raddr),
        .m_rdata_valid (m_rdata_valid),
        .m_rdata_ready (m_rdata_ready),
        .m_rdata       (m_rdata),
        .mem_addrb     (mem_addrb),
        .mem_enb       (mem_enb),
        .mem_regceb    (mem_regceb),
        .mem_doutb     (mem_doutb),
`ifdef SDPRAM_STREAM_READER_ECC_EN
        .mem_sbiterrb  (mem_sbiterrb),
        .mem_dbiterrb  (mem_dbiterrb),
        .m_sbiterr     (m_sbiterr),
        .m_dbiterr     (m_dbiterr),
        .err_cnt       (err_cnt),
`endif
        .inflight      (inflight)
    );

    always #5 clkb = ~clkb;
    always @(posedge clkb) cyc <= cyc + 1;

    // Behavioural RAM port B: data for an enable at cycle N is on mem_doutb in cycle N+2.
    logic [DW-1:0] ram   [64];
    logic          ecc_s [64];
    logic [DW-1:0] st1_q  = '0;
    logic [DW-1:0] dout_q = '0;
    logic          sb1_q  = 1'b0;
    logic          sb_q   = 1'b0;
    always @(posedge clkb) begin
        if (mem_enb) begin
            st1_q <= ram[mem_addrb];
            sb1_q <= ecc_s[mem_addrb];
        end
        if (mem_regceb) begin
            dout_q <= st1_q;
            sb_q   <= sb1_q;
        end
    end
    assign mem_doutb = dout_q;
`ifdef SDPRAM_STREAM_READER_ECC_EN
    assign mem_sbiterrb = sb_q;
    assign mem_dbiterrb = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted request owns one credit until its word is popped,
    // and its word becomes visible RL+1 cycles after acceptance, in request order.
    typedef struct {
        logic [DW-1:0] d;
        logic          sb;
        int            t;
    } exp_t;
    exp_t          q[$];
    logic [DW-1:0] got[$];
    logic          got_sb[$];
    int            got_t[$];
    int            n_issue = 0;

    always @(negedge clkb) begin
        logic er;
        logic ev;
        er = !rstb && (q.size() < BD);
        chk("s_raddr_ready", 64'(s_raddr_ready), 64'(er));
        chk("mem_enb", 64'(mem_enb), 64'(s_raddr_valid && er));
        if (rstb) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (q[0].t <= cyc);
            chk("m_rdata_valid", 64'(m_rdata_valid), 64'(ev));
            chk("inflight", 64'(inflight), 64'(q.size()));
            if (s_raddr_valid && er) chk("mem_addrb", 64'(mem_addrb), 64'(s_raddr));
            if (ev) begin
                chk("m_rdata", 64'(m_rdata), 64'(q[0].d));
`ifdef SDPRAM_STREAM_READER_ECC_EN
                chk("m_sbiterr", 64'(m_sbiterr), 64'(q[0].sb));
`endif
            end
            if (ev && m_rdata_ready) begin
                got.push_back(m_rdata);
                got_sb.push_back(q[0].sb);
                got_t.push_back(cyc);
                void'(q.pop_front());
            end
            if (s_raddr_valid && er) begin
                n_issue++;
                q.push_back('{ram[s_raddr], ecc_s[s_raddr], cyc + RL + 1});
            end
        end
    end

    task automatic tick();
        @(posedge clkb);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        int base;
        int stalls;
        int n0;
        int guard;
        for (int i = 0; i < 64; i++) begin
            ram[i]   = $urandom;
            ecc_s[i] = 1'b0;
        end
        ram[5] = 32'hDEADBEEF;

        // Reset state
        @(negedge clkb);
        chk("ready_in_reset", 64'(s_raddr_ready), 64'd0);
        wait_cyc(3);
        rstb = 1'b0;
        @(negedge clkb);
        chk("rst_ready", 64'(s_raddr_ready), 64'd1);
        chk("rst_valid", 64'(m_rdata_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_rdata", 64'(m_rdata), 64'd0);

        // Single read issued at cycle 10
        m_rdata_ready = 1'b1;
        wait_cyc(10);
        s_raddr_valid = 1'b1;
        s_raddr = 6'd5;
        tick();
        s_raddr_valid = 1'b0;
        wait_cyc(12);
        @(negedge clkb);
        chk("single_not_early", 64'(m_rdata_valid), 64'd0);
        wait_cyc(13);
        @(negedge clkb);
        chk("single_valid_c13", 64'(m_rdata_valid), 64'd1);
        chk("single_data_c13", 64'(m_rdata), 64'hDEADBEEF);
        wait_cyc(14);
        @(negedge clkb);
        chk("single_inflight_c14", 64'(inflight), 64'd0);

        // Streaming 16 back-to-back
        tick();
        for (int i = 0; i < 16; i++) ram[i] = 32'(i * 3);
        got.delete(); got_t.delete(); got_sb.delete();
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            s_raddr_valid = 1'b1;
            s_raddr = AW'(i);
            @(negedge clkb);
            if (!s_raddr_ready) stalls++;
            tick();
        end
        s_raddr_valid = 1'b0;
        repeat (8) tick();
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_beats", 64'(got.size()), 64'd16);
        if (got.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("stream_data", 64'(got[i]), 64'(i * 3));
            chk("stream_no_bubbles", 64'(got_t[15] - got_t[0]), 64'd15);
        end

        // Backpressure: credit stops issue at BD
        got.delete(); got_t.delete(); got_sb.delete();
        m_rdata_ready = 1'b0;
        base = n_issue;
        for (int i = 0; i < 10; i++) begin
            s_raddr_valid = 1'b1;
            s_raddr = AW'(i);
            tick();
        end
        @(negedge clkb);
        chk("bp_accepted", 64'(n_issue - base), 64'd4);
        chk("bp_ready_low", 64'(s_raddr_ready), 64'd0);
        chk("bp_inflight", 64'(inflight), 64'd4);
        s_raddr_valid = 1'b0;
        tick();
        m_rdata_ready = 1'b1;
        repeat (8) tick();
        chk("bp_beats", 64'(got.size()), 64'd4);
        if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_data", 64'(got[i]), 64'(i * 3));
        end

        // Random valid/ready, 1000 reads
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        n0 = got.size();
        base = n_issue;
        guard = 0;
        while ((n_issue - base) < 1000 && guard < 20000) begin
            s_raddr_valid = 1'($urandom_range(0, 1));
            s_raddr = AW'($urandom_range(0, 63));
            m_rdata_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        s_raddr_valid = 1'b0;
        m_rdata_ready = 1'b1;
        repeat (10) tick();
        chk("rand_issued", 64'(n_issue - base), 64'd1000);
        chk("rand_popped", 64'(got.size() - n0), 64'd1000);
        @(negedge clkb);
        chk("rand_drained", 64'(inflight), 64'd0);

        // Reset with 2 reads in the pipe and 2 words buffered
        m_rdata_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_raddr_valid = 1'b1;
            s_raddr = AW'(10 + i);
            tick();
        end
        s_raddr_valid = 1'b0;
        rstb = 1'b1;
        @(negedge clkb);
        chk("mid_inflight_pre", 64'(inflight), 64'd4);
        tick();
        rstb = 1'b0;
        m_rdata_ready = 1'b1;
        @(negedge clkb);
        chk("mid_valid_post", 64'(m_rdata_valid), 64'd0);
        chk("mid_inflight_post", 64'(inflight), 64'd0);
        n0 = got.size();
        repeat (5) tick();
        chk("mid_no_spurious", 64'(got.size() - n0), 64'd0);
        s_raddr_valid = 1'b1;
        s_raddr = 6'd1;
        tick();
        s_raddr_valid = 1'b0;
        repeat (6) tick();
        chk("mid_new_beats", 64'(got.size() - n0), 64'd1);
        if (got.size() == n0 + 1) chk("mid_new_data", 64'(got[n0]), 64'(ram[1]));

`ifdef SDPRAM_STREAM_READER_ECC_EN
        n0 = got.size();
        ecc_s[22] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_raddr_valid = 1'b1;
            s_raddr = AW'(20 + i);
            tick();
        end
        s_raddr_valid = 1'b0;
        repeat (8) tick();
        chk("ecc_beats", 64'(got.size() - n0), 64'd5);
        if (got.size() == n0 + 5) begin
            for (int i = 0; i < 5; i++) chk("ecc_sbit", 64'(got_sb[n0 + i]), 64'(i == 2));
        end
        @(negedge clkb);
        chk("ecc_err_cnt", 64'(err_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
